// File: rtl/chip8_exec_seq.sv
// chip8_exec_seq: multi-cycle CHIP-8 execute stage with memory-backed stack.
// Ports: clk/rst, start+opcode+vx/vy/v0/pc in; busy/done/err, Vx/VF/PC/I
// writebacks, stack mem req/ack, sp out.
module chip8_exec_seq #(
  parameter int          ADDR_W      = 12,
  parameter int          STACK_DEPTH = 16,
  parameter int          STACK_BASE  = 'h0F0,
  parameter int          SHIFT_VY    = 1,
  parameter logic [7:0]  SEED        = 8'h4A
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [15:0]       opcode,
  input  logic [7:0]        vx,
  input  logic [7:0]        vy,
  input  logic [7:0]        v0,
  input  logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              done,
  output logic [1:0]        err,
  output logic              reg_we,
  output logic [3:0]        reg_waddr,
  output logic [7:0]        reg_wdata,
  output logic              vf_we,
  output logic [7:0]        vf_wdata,
  output logic              pc_we,
  output logic [ADDR_W-1:0] pc_wdata,
  output logic              i_we,
  output logic [ADDR_W-1:0] i_wdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [ADDR_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [ADDR_W-1:0] mem_rdata,
  output logic [7:0]        sp
);

  typedef enum logic [1:0] {IDLE, EXEC, MEM, DONE} state_t;
  state_t state, nxt;

  logic [15:0]       op_q;
  logic [7:0]        vx_q, vy_q, v0_q, rng;
  logic [ADDR_W-1:0] pc_q, tgt_q;

  logic [3:0]        nib, xa, nl;
  logic [7:0]        kk, src;
  logic [ADDR_W-1:0] nnn, pc2, pc4;
  logic [8:0]        sum9;

  logic              c_rwe, c_fwe, c_flag, c_iwe;
  logic              c_call, c_ret, full, go_mem;
  logic [7:0]        c_rdata, rng_nx, slot;
  logic [ADDR_W-1:0] c_pc;
  logic [1:0]        c_err;

  assign nib  = op_q[15:12];
  assign xa   = op_q[11:8];
  assign nl   = op_q[3:0];
  assign kk   = op_q[7:0];
  assign nnn  = ADDR_W'(op_q[11:0]);
  assign pc2  = pc_q + ADDR_W'(2);
  assign pc4  = pc_q + ADDR_W'(4);
  assign sum9 = {1'b0, vx_q} + {1'b0, vy_q};
  assign src  = (SHIFT_VY != 0) ? vy_q : vx_q;
  assign busy = (state != IDLE);

  assign rng_nx = rng[0] ? ((rng >> 1) ^ 8'hB8) : (rng >> 1);

  always_comb begin
    c_rwe   = 1'b0;
    c_rdata = 8'h00;
    c_fwe   = 1'b0;
    c_flag  = 1'b0;
    c_iwe   = 1'b0;
    c_pc    = pc2;
    c_err   = 2'd0;
    c_call  = 1'b0;
    c_ret   = 1'b0;
    unique case (1'b1)
      (op_q == 16'h00EE): c_ret = 1'b1;
      (nib == 4'h1): c_pc = nnn;
      (nib == 4'h2): begin
        c_call = 1'b1;
        c_pc   = nnn;
      end
      (nib == 4'h3): if (vx_q == kk) c_pc = pc4;
      (nib == 4'h4): if (vx_q != kk) c_pc = pc4;
      (nib == 4'h5 && nl == 4'h0):
        if (vx_q == vy_q) c_pc = pc4;
      (nib == 4'h9 && nl == 4'h0):
        if (vx_q != vy_q) c_pc = pc4;
      (nib == 4'h6): begin
        c_rwe   = 1'b1;
        c_rdata = kk;
      end
      (nib == 4'h7): begin
        c_rwe   = 1'b1;
        c_rdata = vx_q + kk;
      end
      (nib == 4'h8): begin
        c_rwe = 1'b1;
        case (nl)
          4'h0: c_rdata = vy_q;
          4'h1: c_rdata = vx_q | vy_q;
          4'h2: c_rdata = vx_q & vy_q;
          4'h3: c_rdata = vx_q ^ vy_q;
          4'h4: begin
            c_rdata = sum9[7:0];
            c_fwe   = 1'b1;
            c_flag  = sum9[8];
          end
          4'h5: begin
            c_rdata = vx_q - vy_q;
            c_fwe   = 1'b1;
            c_flag  = (vx_q >= vy_q);
          end
          4'h6: begin
            c_rdata = src >> 1;
            c_fwe   = 1'b1;
            c_flag  = src[0];
          end
          4'h7: begin
            c_rdata = vy_q - vx_q;
            c_fwe   = 1'b1;
            c_flag  = (vy_q >= vx_q);
          end
          4'hE: begin
            c_rdata = src << 1;
            c_fwe   = 1'b1;
            c_flag  = src[7];
          end
          default: begin
            c_rwe = 1'b0;
            c_err = 2'd3;
          end
        endcase
      end
      (nib == 4'hA): c_iwe = 1'b1;
      (nib == 4'hB): c_pc = nnn + ADDR_W'(v0_q);
      (nib == 4'hC): begin
        c_rwe   = 1'b1;
        c_rdata = rng & kk;
      end
      default: c_err = 2'd3;
    endcase
    // VF is written last, so a flag op targeting VF keeps only the flag
    if (c_fwe && xa == 4'hF) c_rwe = 1'b0;
    full = (sp == 8'(STACK_DEPTH));
    if (c_call && full) c_err = 2'd1;
    if (c_ret && sp == 8'd0) c_err = 2'd2;
    go_mem = (c_call && !full) || (c_ret && sp != 8'd0);
    slot   = c_call ? sp : sp - 8'd1;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE: if (start) nxt = EXEC;
      EXEC: nxt = go_mem ? MEM : DONE;
      MEM:  if (mem_req && mem_ack) nxt = DONE;
      DONE: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q      <= 16'h0;
      vx_q      <= 8'h0;
      vy_q      <= 8'h0;
      v0_q      <= 8'h0;
      pc_q      <= '0;
      tgt_q     <= '0;
      rng       <= SEED;
      sp        <= 8'h0;
      done      <= 1'b0;
      err       <= 2'd0;
      reg_we    <= 1'b0;
      reg_waddr <= 4'h0;
      reg_wdata <= 8'h0;
      vf_we     <= 1'b0;
      vf_wdata  <= 8'h0;
      pc_we     <= 1'b0;
      pc_wdata  <= '0;
      i_we      <= 1'b0;
      i_wdata   <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      rng    <= rng_nx;
      done   <= 1'b0;
      reg_we <= 1'b0;
      vf_we  <= 1'b0;
      pc_we  <= 1'b0;
      i_we   <= 1'b0;
      if (state == IDLE && start) begin
        op_q <= opcode;
        vx_q <= vx;
        vy_q <= vy;
        v0_q <= v0;
        pc_q <= pc;
      end
      if (state == EXEC) begin
        if (go_mem) begin
          mem_req   <= 1'b1;
          mem_we    <= c_call;
          mem_addr  <= ADDR_W'(STACK_BASE)
                     + ADDR_W'(slot);
          mem_wdata <= pc2;
          tgt_q     <= c_pc;
        end else begin
          done      <= 1'b1;
          err       <= c_err;
          reg_we    <= c_rwe;
          reg_waddr <= xa;
          reg_wdata <= c_rdata;
          vf_we     <= c_fwe;
          vf_wdata  <= {7'b0, c_flag};
          pc_we     <= (c_err != 2'd1)
                    && (c_err != 2'd2);
          pc_wdata  <= c_pc;
          i_we      <= c_iwe;
          i_wdata   <= nnn;
        end
      end
      if (state == MEM && mem_req && mem_ack) begin
        mem_req  <= 1'b0;
        mem_we   <= 1'b0;
        done     <= 1'b1;
        err      <= 2'd0;
        pc_we    <= 1'b1;
        pc_wdata <= mem_we ? tgt_q : mem_rdata;
        sp       <= mem_we ? sp + 8'd1 : sp - 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_chip8_exec_seq.sv
// tb_chip8_exec_seq: directed checks for chip8_exec_seq.
// Runs with STACK_DEPTH=2 so stack overflow is reachable.
module tb_chip8_exec_seq;

  localparam int AW = 12;
  localparam logic [7:0] SEED = 8'h4A;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [15:0]   opcode = 16'h0;
  logic [7:0]    vx = 8'h0, vy = 8'h0, v0 = 8'h0;
  logic [AW-1:0] pc = '0;
  logic          mem_ack = 1'b0;
  logic [AW-1:0] mem_rdata = '0;

  logic          busy, done, reg_we, vf_we, pc_we, i_we;
  logic          mem_req, mem_we;
  logic [1:0]    err;
  logic [3:0]    reg_waddr;
  logic [7:0]    reg_wdata, vf_wdata, sp;
  logic [AW-1:0] pc_wdata, i_wdata, mem_addr, mem_wdata;

  always #5 clk = ~clk;

  chip8_exec_seq #(
    .ADDR_W(AW), .STACK_DEPTH(2), .STACK_BASE('h0F0),
    .SHIFT_VY(1), .SEED(SEED)
  ) u_dut (
    .clk(clk), .rst(rst), .start(start), .opcode(opcode),
    .vx(vx), .vy(vy), .v0(v0), .pc(pc),
    .busy(busy), .done(done), .err(err),
    .reg_we(reg_we), .reg_waddr(reg_waddr), .reg_wdata(reg_wdata),
    .vf_we(vf_we), .vf_wdata(vf_wdata),
    .pc_we(pc_we), .pc_wdata(pc_wdata),
    .i_we(i_we), .i_wdata(i_wdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .sp(sp)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] lfsr(input logic [7:0] r);
    return r[0] ? ((r >> 1) ^ 8'hB8) : (r >> 1);
  endfunction

  int            lat;
  logic          saw_req, cap_we;
  logic [AW-1:0] cap_addr, cap_wdata;

  // Issue one opcode, ack any stack request after dly cycles,
  // and return at the negedge where done is high.
  task automatic run(input logic [15:0] o, input logic [7:0] a,
                     input logic [7:0] b, input logic [7:0] c,
                     input logic [AW-1:0] p, input int dly,
                     input logic [AW-1:0] rd);
    int w;
    w = 0;
    saw_req = 1'b0;
    cap_we = 1'b0;
    cap_addr = '0;
    cap_wdata = '0;
    @(negedge clk);
    opcode = o; vx = a; vy = b; v0 = c; pc = p; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (!done && lat < 40) begin
      if (mem_req) begin
        if (!saw_req) begin
          saw_req = 1'b1;
          cap_we = mem_we;
          cap_addr = mem_addr;
          cap_wdata = mem_wdata;
        end
        if (w == dly) begin
          mem_ack = 1'b1;
          mem_rdata = rd;
        end
        w++;
      end
      @(negedge clk);
      mem_ack = 1'b0;
      lat++;
    end
    if (!done) chk("done_timeout", done, 1);
  endtask

  task automatic count_done(input int cycles, output int cnt);
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done) cnt++;
    end
  endtask

  int cnt;

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sp", sp, 0);
    chk("rst_memreq", mem_req, 0);
    chk("rst_pcwdata", pc_wdata, 0);

    // rng seen in EXEC is two LFSR steps past SEED: 4A->25->AA
    run(16'hC0F0, 8'h00, 8'h00, 8'h00, 12'h100, 0, '0);
    chk("rnd_data", reg_wdata, lfsr(lfsr(SEED)) & 8'hF0);
    chk("rnd_we", reg_we, 1);

    run(16'h6A37, 8'h00, 8'h00, 8'h00, 12'h200, 0, '0);
    chk("ld_lat", lat, 2);
    chk("ld_we", reg_we, 1);
    chk("ld_addr", reg_waddr, 4'hA);
    chk("ld_data", reg_wdata, 8'h37);
    chk("ld_pc", pc_wdata, 12'h202);
    chk("ld_pcwe", pc_we, 1);
    chk("ld_err", err, 0);
    @(negedge clk);
    chk("ld_done_pulse", done, 0);
    chk("ld_we_pulse", reg_we, 0);
    chk("ld_busy_fall", busy, 0);

    run(16'h8124, 8'hF0, 8'h20, 8'h00, 12'h200, 0, '0);
    chk("add_data", reg_wdata, 8'h10);
    chk("add_vf", vf_wdata, 1);
    chk("add_vfwe", vf_we, 1);
    chk("add_we", reg_we, 1);

    run(16'h8F24, 8'hF0, 8'h20, 8'h00, 12'h200, 0, '0);
    chk("addf_we", reg_we, 0);
    chk("addf_vfwe", vf_we, 1);
    chk("addf_vf", vf_wdata, 1);

    run(16'h8127, 8'h30, 8'h10, 8'h00, 12'h200, 0, '0);
    chk("subn_data", reg_wdata, 8'hE0);
    chk("subn_vf", vf_wdata, 0);

    run(16'h812E, 8'h00, 8'h81, 8'h00, 12'h200, 0, '0);
    chk("shl_data", reg_wdata, 8'h02);
    chk("shl_vf", vf_wdata, 1);

    run(16'h2345, 8'h00, 8'h00, 8'h00, 12'h200, 3, '0);
    chk("call_lat", lat, 6);
    chk("call_memwe", cap_we, 1);
    chk("call_addr", cap_addr, 12'h0F0);
    chk("call_wdata", cap_wdata, 12'h202);
    chk("call_pc", pc_wdata, 12'h345);
    chk("call_sp", sp, 1);
    chk("call_err", err, 0);

    run(16'h00EE, 8'h00, 8'h00, 8'h00, 12'h345, 0, 12'h202);
    chk("ret_lat", lat, 3);
    chk("ret_memwe", cap_we, 0);
    chk("ret_addr", cap_addr, 12'h0F0);
    chk("ret_pc", pc_wdata, 12'h202);
    chk("ret_sp", sp, 0);

    run(16'h00EE, 8'h00, 8'h00, 8'h00, 12'h210, 0, '0);
    chk("udf_err", err, 2);
    chk("udf_pcwe", pc_we, 0);
    chk("udf_req", saw_req, 0);

    run(16'h2100, 8'h00, 8'h00, 8'h00, 12'h010, 0, '0);
    run(16'h2200, 8'h00, 8'h00, 8'h00, 12'h100, 1, '0);
    chk("call2_addr", cap_addr, 12'h0F1);
    chk("call2_sp", sp, 2);
    run(16'h2300, 8'h00, 8'h00, 8'h00, 12'h200, 0, '0);
    chk("ovf_err", err, 1);
    chk("ovf_pcwe", pc_we, 0);
    chk("ovf_req", saw_req, 0);
    chk("ovf_sp", sp, 2);
    run(16'h00EE, 8'h00, 8'h00, 8'h00, 12'h200, 0, 12'h102);
    chk("ret2_addr", cap_addr, 12'h0F1);
    chk("ret2_pc", pc_wdata, 12'h102);
    run(16'h00EE, 8'h00, 8'h00, 8'h00, 12'h102, 2, 12'h012);
    chk("ret1_addr", cap_addr, 12'h0F0);
    chk("ret1_sp", sp, 0);

    run(16'h3155, 8'h55, 8'h00, 8'h00, 12'h300, 0, '0);
    chk("se_pc", pc_wdata, 12'h304);
    run(16'h4155, 8'h55, 8'h00, 8'h00, 12'h300, 0, '0);
    chk("sne_pc", pc_wdata, 12'h302);
    run(16'hBFFE, 8'h00, 8'h00, 8'h04, 12'h300, 0, '0);
    chk("jp_wrap", pc_wdata, 12'h002);
    run(16'hA123, 8'h00, 8'h00, 8'h00, 12'h300, 0, '0);
    chk("ldi_we", i_we, 1);
    chk("ldi_data", i_wdata, 12'h123);
    run(16'hE09E, 8'h00, 8'h00, 8'h00, 12'h300, 0, '0);
    chk("ill_err", err, 3);
    chk("ill_pc", pc_wdata, 12'h302);
    chk("ill_pcwe", pc_we, 1);
    chk("ill_we", reg_we, 0);

    // start held high across the busy window
    @(negedge clk);
    opcode = 16'h6A37; pc = 12'h400; start = 1'b1;
    @(negedge clk);
    opcode = 16'h6B99;
    chk("ign_busy", busy, 1);
    @(negedge clk);
    chk("ign_done", done, 1);
    chk("ign_addr", reg_waddr, 4'hA);
    @(negedge clk);
    start = 1'b0;
    chk("ign_idle", busy, 0);
    count_done(4, cnt);
    chk("ign_nodone", cnt, 0);

    // reset while waiting on the stack memory
    @(negedge clk);
    opcode = 16'h2456; pc = 12'h500; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("rmem_req", mem_req, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rmem_reqdrop", mem_req, 0);
    chk("rmem_done", done, 0);
    count_done(4, cnt);
    chk("rmem_nodone", cnt, 0);
    chk("rmem_sp", sp, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
